// File: rtl/multiword_add_ctrl_pkg.sv
// Shared constants and FSM encoding for the multiword adder controller.
package multiword_add_ctrl_pkg;
  localparam int WORD_W    = 32;
  localparam int MAX_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Word index width; a single-word build still needs a 1-bit index.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction
endpackage

// File: rtl/multiword_add_ctrl_adder_32b.sv
// Single 32-bit adder with carry in/out, shared across all words of an operation.
module adder_32b
  import multiword_add_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              carry_in,
  output logic [WORD_W-1:0] sum,
  output logic              carry_out
);
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, carry_in};
endmodule

// File: rtl/multiword_add_ctrl.sv
// Word-serial multiword adder: one 32-bit add per clock, LSB word first.
// Optional subtract mode (a - b) is enabled by defining MULTIWORD_ADD_SUB_EN.
module multiword_add_ctrl
  import multiword_add_ctrl_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    carry_in,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic                    sub,
`endif
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  output logic [WORD_W*WORDS-1:0] sum,
  output logic                    carry_out,
  output logic                    busy,
  output logic                    done
);
  localparam int IDX_W = idx_width(WORDS);

  state_e state_q, state_d;

  logic [WORDS-1:0][WORD_W-1:0] a_q, b_q, sum_q;
  logic [IDX_W-1:0]             idx_q;
  logic                         carry_q;
  logic                         cout_q;
  logic                         sub_q;
  logic                         sub_sel;

  logic [WORD_W-1:0] add_a, add_b, add_sum;
  logic              add_co;
  logic              accept, last;

`ifdef MULTIWORD_ADD_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign accept = (state_q == IDLE) && start;
  assign last   = (idx_q == IDX_W'(WORDS - 1));

  // Subtraction is a + ~b + 1: invert the b word, seed the carry with 1 at accept.
  assign add_a = a_q[idx_q];
  assign add_b = b_q[idx_q] ^ {WORD_W{sub_q}};

  adder_32b u_adder (
    .a         (add_a),
    .b         (add_b),
    .carry_in  (carry_q),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Datapath: operand capture at accept, one word retired per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sub_q   <= sub_sel;
      carry_q <= sub_sel ? 1'b1 : carry_in;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[idx_q] <= add_sum;
      carry_q      <= add_co;
      idx_q        <= last ? '0 : idx_q + 1'b1;
      if (last) cout_q <= add_co;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed bench for multiword_add_ctrl (WORDS=4 main instance, WORDS=1 side instance).
module tb_multiword_add_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, start, carry_in;
  logic [32*W-1:0] a, b, sum;
  logic           carry_out, busy, done;

  logic           start1, cin1;
  logic [31:0]    a1, b1, sum1;
  logic           co1, busy1, done1;

`ifdef MULTIWORD_ADD_SUB_EN
  logic sub, sub1;
`endif

  int checks   = 0;
  int failures = 0;

  multiword_add_ctrl #(.WORDS(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .carry_in(carry_in),
`ifdef MULTIWORD_ADD_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .sum(sum), .carry_out(carry_out), .busy(busy), .done(done)
  );

  multiword_add_ctrl #(.WORDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .carry_in(cin1),
`ifdef MULTIWORD_ADD_SUB_EN
    .sub(sub1),
`endif
    .a(a1), .b(b1), .sum(sum1), .carry_out(co1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    a        = {$urandom, $urandom, $urandom, $urandom};
    b        = {$urandom, $urandom, $urandom, $urandom};
    carry_in = 1'($urandom);
  endtask

  // Accepts one op from IDLE, scrambles inputs while it runs, returns latency
  // (cycles after accept until done) and whether busy stayed high meanwhile.
  // Ends one cycle past done, back in IDLE.
  task automatic run_op(input logic [32*W-1:0] xa, input logic [32*W-1:0] xb,
                        input logic xc, output int lat, output logic busy_ok);
    a = xa; b = xb; carry_in = xc; start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    lat     = 1;
    busy_ok = busy;
    while (!done && lat < 20) begin
      scramble();
      @(posedge clk); #1;
      lat++;
      busy_ok &= busy;
    end
    @(posedge clk); #1;
  endtask

  int               lat;
  logic             bok, seen;
  logic [32*W:0]    exp;
  logic [32*W-1:0]  xa, xb;
  logic             xc;
  logic [32*W-1:0]  pa [3];
  logic [32*W-1:0]  pb [3];
  logic             pc [3];

  initial begin
    rst_n = 1'b0; start = 1'b0; carry_in = 1'b0; a = '0; b = '0;
    start1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
`ifdef MULTIWORD_ADD_SUB_EN
    sub = 1'b0; sub1 = 1'b0;
`endif

    // Reset state, during and after reset
    repeat (2) @(posedge clk); #1;
    chk("rst_sum", 160'(sum), 160'd0);
    chk("rst_cout", 160'(carry_out), 160'd0);
    chk("rst_busy", 160'(busy), 160'd0);
    chk("rst_done", 160'(done), 160'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("post_rst_sum", 160'(sum), 160'd0);
    chk("post_rst_busy", 160'(busy), 160'd0);
    chk("post_rst_done", 160'(done), 160'd0);

    // Full-width carry ripple: (2^128-1) + 1
    run_op({128{1'b1}}, 128'd1, 1'b0, lat, bok);
    chk("ripple_lat", 160'(lat), 160'd5);
    chk("ripple_busy", 160'(bok), 160'd1);
    chk("ripple_res", 160'({carry_out, sum}), 160'({1'b1, 128'd0}));
    chk("ripple_done_pulse", 160'(done), 160'd0);
    chk("ripple_idle", 160'(busy), 160'd0);

    // Result holds while idle with inputs wiggling
    scramble();
    repeat (3) @(posedge clk); #1;
    chk("hold_res", 160'({carry_out, sum}), 160'({1'b1, 128'd0}));

    run_op(128'd1, 128'd6, 1'b1, lat, bok);
    chk("a1_b6_c1", 160'({carry_out, sum}), 160'd8);
    run_op(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd0, 1'b1, lat, bok);
    chk("word_carry", 160'({carry_out, sum}), 160'({1'b0, 128'h1_0000_0000}));
    run_op('0, '0, 1'b0, lat, bok);
    chk("zero", 160'({carry_out, sum}), 160'd0);
    run_op({128{1'b1}}, {128{1'b1}}, 1'b1, lat, bok);
    chk("max_max_c1", 160'({carry_out, sum}), 160'({1'b1, {128{1'b1}}}));

    // Random vectors against a 129-bit reference
    for (int i = 0; i < 200; i++) begin
      xa  = {$urandom, $urandom, $urandom, $urandom};
      xb  = {$urandom, $urandom, $urandom, $urandom};
      xc  = 1'($urandom);
      exp = {1'b0, xa} + {1'b0, xb} + 129'(xc);
      run_op(xa, xb, xc, lat, bok);
      chk($sformatf("rand%0d", i), 160'({carry_out, sum}), 160'(exp));
    end

    // start held high: back-to-back ops, one done every 6 cycles
    for (int k = 0; k < 3; k++) begin
      pa[k] = {$urandom, $urandom, $urandom, $urandom};
      pb[k] = {$urandom, $urandom, $urandom, $urandom};
      pc[k] = 1'($urandom);
    end
    a = pa[0]; b = pb[0]; carry_in = pc[0]; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      lat = 1;
      while (!done && lat < 20) begin
        scramble();
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("b2b_lat%0d", k), 160'(lat), 160'd5);
      exp = {1'b0, pa[k]} + {1'b0, pb[k]} + 129'(pc[k]);
      chk($sformatf("b2b_res%0d", k), 160'({carry_out, sum}), 160'(exp));
      if (k < 2) begin
        a = pa[k+1]; b = pb[k+1]; carry_in = pc[k+1];
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("b2b_gap_done%0d", k), 160'(done), 160'd0);
      chk($sformatf("b2b_gap_busy%0d", k), 160'(busy), 160'd0);
      @(posedge clk); #1;
    end

    // Reset in the middle of RUN
    a = 128'd5; b = 128'd9; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_sum", 160'(sum), 160'd0);
    chk("midrst_busy", 160'(busy), 160'd0);
    chk("midrst_done", 160'(done), 160'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen |= done;
    end
    chk("midrst_no_done", 160'(seen), 160'd0);
    run_op(128'd3, 128'd4, 1'b0, lat, bok);
    chk("midrst_next_res", 160'({carry_out, sum}), 160'd7);
    chk("midrst_next_lat", 160'(lat), 160'd5);

    // Single-word instance: done two cycles after accept
    a1 = 32'hFFFF_FFFF; b1 = 32'd2; cin1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w1_lat", 160'(lat), 160'd2);
    chk("w1_res", 160'({co1, sum1}), 160'({1'b1, 32'd1}));
    @(posedge clk); #1;

`ifdef MULTIWORD_ADD_SUB_EN
    sub = 1'b1;
    run_op(128'd5, 128'd7, 1'b0, lat, bok);
    chk("sub_5m7", 160'({carry_out, sum}), 160'({1'b0, {127{1'b1}}, 1'b0}));
    run_op(128'd7, 128'd5, 1'b0, lat, bok);
    chk("sub_7m5", 160'({carry_out, sum}), 160'({1'b1, 128'd2}));
    sub = 1'b0;

    a1 = 32'd9; b1 = 32'd4; cin1 = 1'b0; sub1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w1_sub_lat", 160'(lat), 160'd2);
    chk("w1_sub_res", 160'({co1, sum1}), 160'({1'b1, 32'd5}));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 SHALL have parameter: WORDS, default 4, number of 32-bit words per operand; legal range 1..16.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: start  input  1  request an operation; sampled only in IDLE.
REQ-005 SHALL have port: carry_in  input  1  carry into word 0.
REQ-006 SHALL have port: a  input  32*WORDS  operand A, word 0 in bits [31:0].
REQ-007 SHALL have port: b  input  32*WORDS  operand B, same packing as a.
REQ-008 SHALL have port: sum  output  32*WORDS  result, same packing as a; registered.
REQ-009 SHALL have port: carry_out  output  1  carry out of word WORDS-1; registered.
REQ-010 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-011 SHALL have port: done  output  1  one-cycle pulse; result valid.

Function
REQ-012 SHALL time-share one 32-bit adder, one word per clock, LSB word first, carry chained through a carry register.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE with start=1 at an edge: SHALL latch a, b into operand registers, load carry register with carry_in, clear word index to 0, and go to RUN.
REQ-015 RUN, each edge: SHALL write adder sum into sum word[index], load carry register with adder carry, increment index.
REQ-016 RUN with index = WORDS-1: SHALL also write carry_out and go to DONE.
REQ-017 DONE: SHALL assert done for exactly one cycle, then return to IDLE.
REQ-018 Latency: done SHALL be high in cycle WORDS+1 after the start-accept edge; WORDS=1 gives done 2 cycles after start.
REQ-019 start during RUN or DONE SHALL be ignored; no queuing. The earliest new accept is the edge at the end of the DONE cycle's following IDLE cycle.
REQ-020 Changes on a, b, or carry_in after the accept edge SHALL NOT affect the result.
REQ-021 sum words SHALL update progressively during RUN; sum and carry_out are valid only from the done cycle and SHALL hold until the next accepted start.
REQ-022 Arithmetic: {carry_out, sum} SHALL equal a + b + carry_in, modulo 2^(32*WORDS+1).

Reset
REQ-023 rst_n low SHALL immediately force IDLE and clear sum, carry_out, busy, done, index, carry register, and operand registers to 0.
REQ-024 Reset mid-RUN SHALL abandon the operation with no done pulse; the first start after release SHALL behave per REQ-014.

Configuration
REQ-025 With macro MULTIWORD_ADD_SUB_EN defined: SHALL add input port sub (1 bit), latched at accept; when sub=1, each b word is inverted and the carry register is loaded with 1, ignoring carry_in, giving a - b, with carry_out=1 meaning no borrow.
REQ-026 Without MULTIWORD_ADD_SUB_EN: SHALL have no sub port, and behaviour SHALL be per REQ-022 only.

Structure
REQ-027 Shared package SHALL hold WORD_W=32, the FSM state encoding (IDLE, RUN, DONE), and MAX_WORDS=16.
REQ-028 The 32-bit adder SHALL be a sub-module instance of adder_32b (ports a, b, carry_in, sum, carry_out); the controller contains no other adder.

Verification (WORDS=4 unless stated)
REQ-029 Reset asserted -> sum=0, carry_out=0, busy=0, done=0, both during reset and after release with start=0.
REQ-030 a=2^128-1, b=1, carry_in=0, start pulse -> sum=0, carry_out=1, done on cycle 5 after accept, busy high cycles 1-5.
REQ-031 a=1, b=6, carry_in=1 -> sum=8, carry_out=0; then 200 random {carry_in,a,b} sets compared against the reference sum, 0 mismatches.
REQ-032 start held high continuously, and a/b changed during RUN -> exactly one done per 6 cycles; each result matches the operands latched at its accept.
REQ-033 rst_n pulsed low at cycle 2 of RUN -> outputs 0, no done; next start with a=3, b=4 -> sum=7.
REQ-034 MULTIWORD_ADD_SUB_EN defined, sub=1, a=5, b=7 -> sum=2^128-2, carry_out=0; a=7, b=5 -> sum=2, carry_out=1; WORDS=1 build -> done 2 cycles after accept.
